// File: rtl/cache_trigger_queue.sv
// Trigger event queue for PRM firmware: never back-pressures the control plane,
// suppresses consecutive duplicate DSids, counts drops when full, raises a holdoff/half-full irq.
module cache_trigger_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned HOLDOFF = 64
) (
  input  logic                     SYS_CLK,
  input  logic                     RST,
  input  logic                     trigger_axis_tvalid,
  input  logic [15:0]              trigger_axis_tdata,
  output logic                     trigger_axis_tready,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [15:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              drop_cnt,
  output logic [15:0]              dup_cnt,
  input  logic                     clr,
  output logic                     irq
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(HOLDOFF + 1);

  logic [15:0]   r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [TW-1:0] r_timer;
  logic [15:0]   r_rd_data, r_drop_cnt, r_dup_cnt;
  logic          r_rd_valid, r_irq, r_tready;

  logic          w_pop, w_try, w_dup, w_drop, w_push;
  logic [CW-1:0] w_eff, w_count_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [15:0]   w_newest, w_head_nxt;
  logic [TW-1:0] w_timer_nxt;
  logic          w_irq_nxt;

  // Dedupe is judged against the newest entry, using occupancy net of a same-cycle pop.
  always_comb begin
    w_pop        = rd_en & r_rd_valid;
    w_eff        = r_count - CW'(w_pop);
    w_newest     = r_mem[r_wr_ptr - PW'(1)];
    w_try        = trigger_axis_tvalid & r_tready;
    w_dup        = w_try & (w_eff != '0) & (trigger_axis_tdata == w_newest);
    w_drop       = w_try & ~w_dup & (w_eff == CW'(DEPTH));
    w_push       = w_try & ~w_dup & ~w_drop;
    w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
    w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
    w_head_nxt   = 16'h0000;
    if (w_count_nxt != '0) begin
      // The head is the word being written when the queue was otherwise drained.
      if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) w_head_nxt = trigger_axis_tdata;
      else                                      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
    w_timer_nxt = '0;
    if (!(clr || w_pop || !r_rd_valid))
      w_timer_nxt = (r_timer == TW'(HOLDOFF)) ? r_timer : r_timer + TW'(1);
    w_irq_nxt = (w_count_nxt != '0) &&
                ((w_timer_nxt == TW'(HOLDOFF)) || (w_count_nxt >= CW'(DEPTH / 2)));
  end

  always_ff @(posedge SYS_CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= trigger_axis_tdata;
  end

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      r_tready   <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_timer    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 16'h0000;
      r_drop_cnt <= 16'h0000;
      r_dup_cnt  <= 16'h0000;
      r_irq      <= 1'b0;
    end else begin
      r_tready   <= 1'b1;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_wr_ptr   <= r_wr_ptr + PW'(w_push);
      r_count    <= w_count_nxt;
      r_timer    <= w_timer_nxt;
      r_rd_valid <= (w_count_nxt != '0);
      r_rd_data  <= w_head_nxt;
      r_irq      <= w_irq_nxt;
      // Saturating event counters; clear takes priority over a same-cycle event.
      if (clr)                                  r_drop_cnt <= 16'h0000;
      else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (clr)                                  r_dup_cnt  <= 16'h0000;
      else if (w_dup && r_dup_cnt != 16'hFFFF)   r_dup_cnt  <= r_dup_cnt + 16'd1;
    end
  end

  assign trigger_axis_tready = r_tready;
  assign rd_valid            = r_rd_valid;
  assign rd_data             = r_rd_data;
  assign count               = r_count;
  assign drop_cnt            = r_drop_cnt;
  assign dup_cnt             = r_dup_cnt;
  assign irq                 = r_irq;

endmodule

// File: tb/tb_cache_trigger_queue.sv
// Bench for cache_trigger_queue: directed scenarios plus random traffic against a queue-based model.
module tb_cache_trigger_queue;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned HOLDOFF = 64;

  logic        SYS_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        tvalid = 1'b0;
  logic [15:0] tdata = 16'h0;
  logic        tready;
  logic        rd_en = 1'b0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [3:0]  count;
  logic [15:0] drop_cnt, dup_cnt;
  logic        clr = 1'b0;
  logic        irq;

  cache_trigger_queue #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
    .SYS_CLK(SYS_CLK), .RST(RST),
    .trigger_axis_tvalid(tvalid), .trigger_axis_tdata(tdata), .trigger_axis_tready(tready),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
    .drop_cnt(drop_cnt), .dup_cnt(dup_cnt), .clr(clr), .irq(irq)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] q[$];
  int          m_drop, m_dup, m_timer;
  bit          m_ready, m_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_drop = 0; m_dup = 0; m_timer = 0; m_ready = 0; m_irq = 0;
  endtask

  task automatic model_step(input bit v, input logic [15:0] d, input bit r, input bit c);
    bit pop, push, was_empty;
    int eff;
    pop = r && (q.size() > 0);
    eff = q.size() - int'(pop);
    was_empty = (q.size() == 0);
    push = 0;
    if (v && m_ready) begin
      if (eff > 0 && d == q[q.size()-1]) begin
        if (m_dup < 65535) m_dup++;
      end else if (eff == DEPTH) begin
        if (m_drop < 65535) m_drop++;
      end else push = 1;
    end
    if (c) begin m_drop = 0; m_dup = 0; end
    if (pop) void'(q.pop_front());
    if (push) q.push_back(d);
    if (c || pop || was_empty) m_timer = 0;
    else if (m_timer < HOLDOFF) m_timer++;
    m_irq = (q.size() > 0) && (m_timer == HOLDOFF || q.size() >= DEPTH / 2);
    m_ready = 1;
  endtask

  task automatic check_all(input string tag);
    logic [15:0] head;
    head = (q.size() > 0) ? q[0] : 16'h0;
    check({tag, ".tready"},   32'(tready),   32'(m_ready));
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(q.size() > 0));
    check({tag, ".rd_data"},  32'(rd_data),  32'(head));
    check({tag, ".count"},    32'(count),    32'(q.size()));
    check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
    check({tag, ".dup_cnt"},  32'(dup_cnt),  32'(m_dup));
    check({tag, ".irq"},      32'(irq),      32'(m_irq));
  endtask

  // One clock: drive inputs away from the edge, advance the model at the edge, check after it.
  task automatic cyc(input bit v, input logic [15:0] d, input bit r, input bit c);
    tvalid = v; tdata = d; rd_en = r; clr = c;
    @(posedge SYS_CLK);
    model_step(v, d, r, c);
    #1;
    check_all("cyc");
  endtask

  task automatic drain();
    repeat (DEPTH + 2) cyc(1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  initial begin
    int n;
    model_reset();
    // Reset: triggers presented while RST is high are lost.
    tvalid = 1'b1; tdata = 16'h00AA;
    repeat (3) begin
      @(posedge SYS_CLK); #1;
      check_all("reset");
    end
    tvalid = 1'b0;
    RST = 1'b0;
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    check("ready_after_reset", 32'(tready), 32'd1);

    // Basic push/pop ordering.
    cyc(1'b1, 16'h0003, 1'b0, 1'b0);
    cyc(1'b1, 16'h0005, 1'b0, 1'b0);
    check("basic_data", 32'(rd_data), 32'h3);
    check("basic_count", 32'(count), 32'd2);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    check("basic_pop1", 32'(rd_data), 32'h5);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    check("basic_empty_valid", 32'(rd_valid), 32'd0);
    check("basic_empty_data", 32'(rd_data), 32'h0);

    // Dedupe of consecutive repeats only.
    cyc(1'b1, 16'h0007, 1'b0, 1'b0);
    cyc(1'b1, 16'h0007, 1'b0, 1'b0);
    cyc(1'b1, 16'h0007, 1'b0, 1'b0);
    cyc(1'b1, 16'h0008, 1'b0, 1'b0);
    cyc(1'b1, 16'h0007, 1'b0, 1'b0);
    check("dedupe_count", 32'(count), 32'd3);
    check("dedupe_dup", 32'(dup_cnt), 32'd2);
    check("dedupe_pop_a", 32'(rd_data), 32'h7);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    check("dedupe_pop_b", 32'(rd_data), 32'h8);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    check("dedupe_pop_c", 32'(rd_data), 32'h7);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);

    // Pop-through: the only matching entry is popped, so the push is written.
    cyc(1'b1, 16'h0009, 1'b0, 1'b0);
    cyc(1'b1, 16'h0009, 1'b1, 1'b0);
    check("popthru_count", 32'(count), 32'd1);
    check("popthru_data", 32'(rd_data), 32'h9);
    check("popthru_dup", 32'(dup_cnt), 32'd2);
    drain();

    // Full: 10 distinct pushes, 2 dropped, first 8 read back in order.
    for (int i = 0; i < 10; i++) cyc(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
    check("full_count", 32'(count), 32'd8);
    check("full_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 8; i++) begin
      check("full_order", 32'(rd_data), 32'(16'h0100 + i));
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
    cyc(1'b1, 16'h0208, 1'b1, 1'b0);
    cyc(1'b1, 16'h0209, 1'b0, 1'b0);
    check("fullpop_count", 32'(count), 32'd8);
    check("fullpop_drop", 32'(drop_cnt), 32'd1);
    for (int i = 1; i < 9; i++) begin
      check("fullpop_order", 32'(rd_data), 32'(16'h0200 + i));
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
    end
    drain();

    // Holdoff interrupt, bounded wait.
    cyc(1'b1, 16'h0300, 1'b0, 1'b0);
    n = 0;
    while (!irq && n < 4 * HOLDOFF) begin
      cyc(1'b0, 16'h0, 1'b0, 1'b0);
      n++;
    end
    check("irq_latency", 32'(n), 32'(HOLDOFF));
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    check("irq_clear_on_pop", 32'(irq), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("irq_half_pre", 32'(irq), 32'd0);
      cyc(1'b1, 16'(16'h0400 + i), 1'b0, 1'b0);
    end
    check("irq_half", 32'(irq), 32'd1);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    check("irq_half_drop", 32'(irq), 32'd0);
    drain();

    // Random traffic over a small data alphabet to provoke dups, drops and clears.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 99) < 65), 16'($urandom_range(0, 3)),
          1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 2));
    end
    drain();
    cyc(1'b0, 16'h0, 1'b0, 1'b1);

    // Drop counter saturation, then clear beating a same-cycle drop.
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'(16'h0500 + i), 1'b0, 1'b0);
    repeat (65540) cyc(1'b1, 16'hBEEF, 1'b0, 1'b0);
    check("drop_sat", 32'(drop_cnt), 32'hFFFF);
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b0);
    check("drop_sat_hold", 32'(drop_cnt), 32'hFFFF);
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b1);
    check("drop_clr", 32'(drop_cnt), 32'h0);
    drain();

    // Asynchronous reset with count=5.
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'(16'h0600 + i), 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 32'd5);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check("arst_count", 32'(count), 32'd0);
    check("arst_valid", 32'(rd_valid), 32'd0);
    check("arst_data", 32'(rd_data), 32'd0);
    check("arst_tready", 32'(tready), 32'd0);
    check("arst_irq", 32'(irq), 32'd0);
    check_all("arst");
    @(posedge SYS_CLK); #1;
    RST = 1'b0;
    cyc(1'b0, 16'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
